// File: rtl/fft_pkg.sv
// Shared FFT constants and the complex-sample type used by FFT_top and its output serializer.
package fft_pkg;
    localparam int DW    = 16;
    localparam int NPTS  = 8;
    localparam int LOG2N = 3;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPTS - 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef cplx_t [NPTS-1:0] frame_t;
endpackage

// File: rtl/fft_p2s_out_if.sv
// Streaming bin interface: one complex bin per beat over valid/ready.
interface fft_p2s_out_if;
    import fft_pkg::*;

    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_re;
    logic [DW-1:0]    m_im;
    logic [LOG2N-1:0] m_idx;
    logic             m_last;

    modport master (output m_valid, m_re, m_im, m_idx, m_last, input m_ready);
    modport slave  (input m_valid, m_re, m_im, m_idx, m_last, output m_ready);
endinterface

// File: rtl/fft_frame_bank.sv
// One frame of complex bins: parallel write-all, read-by-index. Cleared on reset.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  frame_t           wdata_i,
    input  logic [LOG2N-1:0] raddr_i,
    output cplx_t            rdata_o
);
    frame_t mem_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  mem_q <= '0;
        else if (we_i) mem_q <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft_p2s_out.sv
// FFT output serializer: ping-pong capture of 8 bins, streamed in natural order.
module fft_p2s_out
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_valid,
    input  logic [DW-1:0]       X_0_re,
    input  logic [DW-1:0]       X_0_im,
    input  logic [DW-1:0]       X_1_re,
    input  logic [DW-1:0]       X_1_im,
    input  logic [DW-1:0]       X_2_re,
    input  logic [DW-1:0]       X_2_im,
    input  logic [DW-1:0]       X_3_re,
    input  logic [DW-1:0]       X_3_im,
    input  logic [DW-1:0]       X_4_re,
    input  logic [DW-1:0]       X_4_im,
    input  logic [DW-1:0]       X_5_re,
    input  logic [DW-1:0]       X_5_im,
    input  logic [DW-1:0]       X_6_re,
    input  logic [DW-1:0]       X_6_im,
    input  logic [DW-1:0]       X_7_re,
    input  logic [DW-1:0]       X_7_im,
    input  logic                clr_ovf,
    fft_p2s_out_if.master       m,
    output logic                overflow,
    output logic [7:0]          frame_cnt
);
    frame_t wdata;
    assign wdata[0] = '{re: X_0_re, im: X_0_im};
    assign wdata[1] = '{re: X_1_re, im: X_1_im};
    assign wdata[2] = '{re: X_2_re, im: X_2_im};
    assign wdata[3] = '{re: X_3_re, im: X_3_im};
    assign wdata[4] = '{re: X_4_re, im: X_4_im};
    assign wdata[5] = '{re: X_5_re, im: X_5_im};
    assign wdata[6] = '{re: X_6_re, im: X_6_im};
    assign wdata[7] = '{re: X_7_re, im: X_7_im};

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       fcnt_q, fcnt_d;

    logic  vld, xfer, rel, cap, drop;
    cplx_t rd0, rd1, rd_sel;

    assign vld  = (count_q != 2'd0);
    assign xfer = vld && m.m_ready;
    assign rel  = xfer && (idx_q == LAST_IDX);
    // Releasing the last beat frees a bank in the same cycle, so a full buffer can still capture.
    assign cap  = frame_valid && ((count_q != 2'd2) || rel);
    assign drop = frame_valid && !cap;

    fft_frame_bank B0 (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (cap && !wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (idx_q),
        .rdata_o (rd0)
    );

    fft_frame_bank B1 (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (cap && wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (idx_q),
        .rdata_o (rd1)
    );

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        fcnt_d   = fcnt_q;
        case ({cap, rel})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (cap) begin
            wr_ptr_d = ~wr_ptr_q;
            fcnt_d   = fcnt_q + 8'd1;
        end
        // idx wraps 7->0 naturally on the releasing beat.
        if (xfer) idx_d    = idx_q + 1'b1;
        if (rel)  rd_ptr_d = ~rd_ptr_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            fcnt_q   <= 8'd0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign rd_sel    = rd_ptr_q ? rd1 : rd0;
    assign m.m_valid = vld;
    assign m.m_re    = rd_sel.re;
    assign m.m_im    = rd_sel.im;
    assign m.m_idx   = idx_q;
    assign m.m_last  = vld && (idx_q == LAST_IDX);
    assign overflow  = ovf_q;
    assign frame_cnt = fcnt_q;
endmodule
